// File: rtl/controle_comparador_pkg.sv
// Shared types and constants for the nibble-serial word comparator.
package controle_comparador_pkg;

  // Width of the one shared equality comparator.
  localparam int NIBBLE_W = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Equality of two nibbles. It is kept here so the comparator and any
  // future consumer share one definition.
  function automatic logic nibble_eq(
    input logic [NIBBLE_W-1:0] a,
    input logic [NIBBLE_W-1:0] b
  );
    return (a == b);
  endfunction

endpackage

// File: rtl/comparador_nibble.sv
// Combinational 4-bit equality comparator. The sequencer time-shares the
// single instance across all nibbles of the operands.
module comparador_nibble
  import controle_comparador_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  output logic                eq
);

  assign eq = nibble_eq(a, b);

endmodule

// File: rtl/controle_comparador.sv
// Nibble-serial comparator of two wide words. Scans from the most
// significant nibble down through one shared 4-bit comparator. It reports
// equality and the index of the most significant differing nibble.
module controle_comparador
  import controle_comparador_pkg::*;
#(
  parameter int NIBBLES    = 4,
  parameter bit EARLY_EXIT = 1'b1,
  parameter int IW         = $clog2(NIBBLES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a_in,
  input  logic [NIBBLE_W*NIBBLES-1:0] b_in,
  output logic                        busy,
  output logic                        done,
  output logic                        equal,
  output logic [IW-1:0]               mismatch_idx
);

  // Operands are held as arrays of nibbles, so the scan index selects a
  // nibble directly with no multiply in the select path.
  typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] word_t;

  localparam logic [IW-1:0] IDX_TOP  = IW'(NIBBLES - 1);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  state_t        state_r;
  state_t        state_next;
  word_t         a_r;
  word_t         a_next;
  word_t         b_r;
  word_t         b_next;
  logic [IW-1:0] idx_r;
  logic [IW-1:0] idx_next;
  logic          sticky_r;
  logic          sticky_next;
  logic          equal_r;
  logic          equal_next;
  logic [IW-1:0] midx_r;
  logic [IW-1:0] midx_next;
  logic          busy_r;
  logic          done_r;
  logic          nib_eq;

  // The shared comparator always looks at the nibble pair under the index.
  comparador_nibble u_cmp (
    .a  (a_r[idx_r]),
    .b  (b_r[idx_r]),
    .eq (nib_eq)
  );

  // Next-state and next-result logic for the scan sequencer.
  always_comb begin
    state_next  = state_r;
    a_next      = a_r;
    b_next      = b_r;
    idx_next    = idx_r;
    sticky_next = sticky_r;
    equal_next  = equal_r;
    midx_next   = midx_r;

    case (state_r)
      IDLE: begin
        if (start) begin
          // Capture the operands and clear the previous result. Later
          // changes on a_in/b_in cannot affect this comparison.
          a_next      = a_in;
          b_next      = b_in;
          idx_next    = IDX_TOP;
          sticky_next = 1'b0;
          equal_next  = 1'b0;
          midx_next   = IDX_ZERO;
          state_next  = COMPARE;
        end else begin
          state_next  = IDLE;
        end
      end

      COMPARE: begin
        if (nib_eq) begin
          if (idx_r == IDX_ZERO) begin
            // End of scan. The sticky flag is only ever set in full-scan
            // mode, and midx_r still holds the first recorded mismatch or
            // the zero written on start.
            equal_next = ~sticky_r;
            state_next = DONE;
          end else begin
            idx_next   = idx_r - IDX_ONE;
          end
        end else begin
          if (EARLY_EXIT) begin
            equal_next = 1'b0;
            midx_next  = idx_r;
            state_next = DONE;
          end else begin
            // Only the first mismatch, which is the most significant one,
            // is recorded. The scan continues to a fixed latency.
            if (!sticky_r) begin
              midx_next   = idx_r;
              sticky_next = 1'b1;
            end else begin
              midx_next   = midx_r;
            end
            if (idx_r == IDX_ZERO) begin
              equal_next = 1'b0;
              state_next = DONE;
            end else begin
              idx_next   = idx_r - IDX_ONE;
            end
          end
        end
      end

      DONE: begin
        // The result is already registered. Any start seen here is dropped.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, operand and result registers. The flags are registered from the
  // next state, so busy covers exactly the COMPARE cycles and done is a
  // single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      idx_r    <= IDX_ZERO;
      sticky_r <= 1'b0;
      equal_r  <= 1'b0;
      midx_r   <= IDX_ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_next;
      a_r      <= a_next;
      b_r      <= b_next;
      idx_r    <= idx_next;
      sticky_r <= sticky_next;
      equal_r  <= equal_next;
      midx_r   <= midx_next;
      busy_r   <= (state_next == COMPARE);
      done_r   <= (state_next == DONE);
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign equal        = equal_r;
  assign mismatch_idx = midx_r;

endmodule

// File: tb/tb_controle_comparador.sv
// Scoreboard bench for controle_comparador. Three instances are used:
// 4 nibbles with early exit, 4 nibbles with a full scan, and 2 nibbles
// with early exit.
module tb_controle_comparador;

  typedef struct {
    int         dut;
    logic       eq;
    logic [1:0] idx;
    int         done_cyc;
    int         k;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [7:0]  a2 = '0, b2 = '0;
  logic        busy0, busy1, busy2, done0, done1, done2, eq0, eq1, eq2;
  logic [1:0]  midx0, midx1;
  logic [0:0]  midx2;

  logic        busy_v [3];
  logic        done_v [3];
  logic        eq_v   [3];
  logic [1:0]  midx_v [3];

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          busy_cnt [3] = '{0, 0, 0};
  logic        zero_chk = 1'b0;
  logic        all_done = 1'b0;

  controle_comparador #(.NIBBLES(4), .EARLY_EXIT(1'b1)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .a_in(a0), .b_in(b0),
    .busy(busy0), .done(done0), .equal(eq0), .mismatch_idx(midx0));

  controle_comparador #(.NIBBLES(4), .EARLY_EXIT(1'b0)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a_in(a1), .b_in(b1),
    .busy(busy1), .done(done1), .equal(eq1), .mismatch_idx(midx1));

  controle_comparador #(.NIBBLES(2), .EARLY_EXIT(1'b1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a_in(a2), .b_in(b2),
    .busy(busy2), .done(done2), .equal(eq2), .mismatch_idx(midx2));

  assign busy_v[0] = busy0;
  assign busy_v[1] = busy1;
  assign busy_v[2] = busy2;
  assign done_v[0] = done0;
  assign done_v[1] = done1;
  assign done_v[2] = done2;
  assign eq_v[0]   = eq0;
  assign eq_v[1]   = eq1;
  assign eq_v[2]   = eq2;
  assign midx_v[0] = midx0;
  assign midx_v[1] = midx1;
  assign midx_v[2] = {1'b0, midx2};

  always #5 clk = ~clk;

  // Cycle counter. The value after the start edge S is S, so a result with
  // k nibbles examined is expected with cyc == S + k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d, input int got, input int want);
    checks = checks + 1;
    if (got !== want) begin
      errors = errors + 1;
      $display("FAIL %s dut%0d got %0d expected %0d (cyc %0d)", nm, d, got, want, cyc);
    end
  endtask

  // Monitor. It pops one expectation per done pulse and checks the result,
  // the timing and the busy length. It also checks outputs after reset on
  // request, catches missing results, and ends the run.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (reset) busy_cnt[d] = 0;
      else if (busy_v[d] === 1'b1) busy_cnt[d] = busy_cnt[d] + 1;
      if (done_v[d] === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", d, 1, 0);
        end else begin
          e = sb.pop_front();
          chk("dut_id", d, d, e.dut);
          chk("equal", d, int'(eq_v[d]), int'(e.eq));
          chk("mismatch_idx", d, int'(midx_v[d]), int'(e.idx));
          chk("done_cycle", d, cyc, e.done_cyc);
          chk("busy_cycles", d, busy_cnt[d], e.k);
        end
        busy_cnt[d] = 0;
      end
      if (zero_chk) begin
        chk("rst_busy", d, int'(busy_v[d]), 0);
        chk("rst_done", d, int'(done_v[d]), 0);
        chk("rst_equal", d, int'(eq_v[d]), 0);
        chk("rst_midx", d, int'(midx_v[d]), 0);
      end
    end
    if (sb.size() != 0 && cyc > sb[0].done_cyc) begin
      chk("done_timeout", sb[0].dut, cyc, sb[0].done_cyc);
      void'(sb.pop_front());
    end
    if (all_done) begin
      chk("scoreboard_empty", 0, sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // Issue one comparison and queue its hand-computed result.
  task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b,
                       input logic eq, input logic [1:0] idx, input int k);
    @(negedge clk);
    case (d)
      0: begin a0 = a; b0 = b; start0 = 1'b1; end
      1: begin a1 = a; b1 = b; start1 = 1'b1; end
      default: begin a2 = a[7:0]; b2 = b[7:0]; start2 = 1'b1; end
    endcase
    sb.push_back('{d, eq, idx, cyc + 1 + k, k});
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    drain();
  endtask

  initial begin
    int s;
    repeat (2) @(posedge clk);
    #1 zero_chk = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    zero_chk = 1'b0;

    // Early exit, 4 nibbles.
    issue(0, 16'hA5C3, 16'hA5C3, 1'b1, 2'd0, 4);
    issue(0, 16'h1234, 16'h1284, 1'b0, 2'd1, 3);
    issue(0, 16'h1234, 16'h9234, 1'b0, 2'd3, 1);
    issue(0, 16'h0000, 16'h0001, 1'b0, 2'd0, 4);

    // Start is held high and a_in changes mid-run. The retained start is
    // accepted only once the sequencer is back in IDLE, and it then
    // captures the new a_in.
    @(negedge clk);
    a0 = 16'h0000; b0 = 16'h0001; start0 = 1'b1;
    s = cyc + 1;
    sb.push_back('{0, 1'b0, 2'd0, s + 4, 4});
    sb.push_back('{0, 1'b1, 2'd0, s + 10, 4});
    repeat (2) @(posedge clk);
    #1 a0 = 16'h0001;
    repeat (5) @(posedge clk);
    #1 start0 = 1'b0;
    drain();

    // Reset in cycle 2 of a comparison. All outputs must be low and no
    // done pulse may follow.
    @(negedge clk);
    a0 = 16'h1234; b0 = 16'h1234; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    zero_chk = 1'b1;
    @(posedge clk);
    #1 zero_chk = 1'b0;
    repeat (6) @(negedge clk);
    issue(0, 16'hFFFF, 16'hFFFF, 1'b1, 2'd0, 4);

    // Full scan, 4 nibbles. The first (most significant) mismatch is kept.
    issue(1, 16'h1234, 16'h9284, 1'b0, 2'd3, 4);
    issue(1, 16'h5A5A, 16'h5A5A, 1'b1, 2'd0, 4);
    issue(1, 16'h0000, 16'h0001, 1'b0, 2'd0, 4);

    // Early exit, 2 nibbles.
    issue(2, 16'h003C, 16'h003D, 1'b0, 2'd0, 2);
    issue(2, 16'h003C, 16'h004C, 1'b0, 2'd1, 1);
    issue(2, 16'h003C, 16'h003C, 1'b1, 2'd0, 2);

    @(negedge clk);
    all_done = 1'b1;
  end

endmodule
